// File: rtl/float_pkg.sv
// Shared IEEE-754 single-precision definitions for the floating-point execution units.
package float_pkg;

  localparam int unsigned SIGN = 1;
  localparam int unsigned EXP  = 8;
  localparam int unsigned FRAC = 23;
  localparam int unsigned BIAS = 127;

  localparam logic [31:0] QNAN    = 32'h7FC0_0000;
  localparam logic [31:0] POS_INF = 32'h7F80_0000;

  typedef enum logic [1:0] {
    ZERO,
    NORMAL,
    INF,
    NAN
  } fclass_t;

  typedef enum logic [2:0] {
    StIdle,
    StUnpack,
    StMult,
    StNorm,
    StPack
  } mul_state_t;

endpackage

// File: rtl/float_multiply_if.sv
// Operand/result bundle between the instruction reader and the multiplier.
interface float_multiply_if;
  logic [31:0] a;
  logic [31:0] b;
  logic        enable;
  logic [31:0] result;
  logic        valid;
  logic        busy;
  logic [31:0] debug;

  modport master (
    output a, b, enable,
    input  result, valid, busy, debug
  );

  modport slave (
    input  a, b, enable,
    output result, valid, busy, debug
  );
endinterface

// File: rtl/float_unpack.sv
// Splits a single-precision word into fields and classifies it; denormals read as zero.
module float_unpack
  import float_pkg::*;
(
  input  logic [31:0]   word,
  output logic          sign,
  output logic [EXP-1:0] exponent,
  output logic [FRAC:0]  mant,
  output fclass_t       cls
);

  always_comb begin
    sign     = word[31];
    exponent = word[30:23];
    mant     = {1'b1, word[22:0]};
    cls      = NORMAL;
    if (exponent == '0) begin
      cls  = ZERO;
      mant = '0;
    end else if (exponent == '1) begin
      cls = (word[22:0] == '0) ? INF : NAN;
    end
  end

endmodule

// File: rtl/float_multiply.sv
// Multi-cycle single-precision multiplier: unpack, 24x24 multiply, normalise, round/pack.
module float_multiply
  import float_pkg::*;
(
  input logic           clk,
  input logic           reset,
  float_multiply_if.slave bus
);

  mul_state_t state;

  logic [31:0] a_q, b_q;
  logic        sa, sb;
  logic [7:0]  ea, eb;
  logic [23:0] ma, mb;
  fclass_t     ca, cb;

  logic               sign_q;
  logic               special_q;
  logic [31:0]        special_res_q;
  logic [23:0]        ma_q, mb_q;
  logic [7:0]         ea_q, eb_q;
  logic [47:0]        prod_q;
  logic signed [9:0]  exp_q;
  logic [22:0]        mant_q;
  logic               g_q, s_q;

  float_unpack u_unpack_a (
    .word     (a_q),
    .sign     (sa),
    .exponent (ea),
    .mant     (ma),
    .cls      (ca)
  );

  float_unpack u_unpack_b (
    .word     (b_q),
    .sign     (sb),
    .exponent (eb),
    .mant     (mb),
    .cls      (cb)
  );

  logic        special_c;
  logic [31:0] special_res_c;
  logic        sign_c;

  always_comb begin
    sign_c        = sa ^ sb;
    special_c     = 1'b1;
    special_res_c = QNAN;
    if (ca == NAN || cb == NAN) begin
      special_res_c = QNAN;
    end else if ((ca == INF && cb == ZERO) || (ca == ZERO && cb == INF)) begin
      special_res_c = QNAN;
    end else if (ca == INF || cb == INF) begin
      special_res_c = {sign_c, POS_INF[30:0]};
    end else if (ca == ZERO || cb == ZERO) begin
      special_res_c = {sign_c, 31'h0};
    end else begin
      special_c     = 1'b0;
      special_res_c = '0;
    end
  end

  logic [47:0]       prod_c;
  logic signed [9:0] exp_sum_c;

  assign prod_c    = 48'(ma_q) * 48'(mb_q);
  assign exp_sum_c = $signed({2'b00, ea_q}) + $signed({2'b00, eb_q}) - $signed(10'(BIAS));

  logic              round_up_c;
  logic              carry_c;
  logic [22:0]       mant_r_c;
  logic signed [9:0] exp_r_c;
  logic [31:0]       pack_c;
  logic [31:0]       final_c;

  always_comb begin
    round_up_c           = g_q & (s_q | mant_q[0]);
    {carry_c, mant_r_c}  = {1'b0, mant_q} + 24'(round_up_c);
    exp_r_c              = exp_q + $signed(10'(carry_c));
    if (exp_r_c >= 10'sd255) begin
      pack_c = {sign_q, POS_INF[30:0]};
    end else if (exp_r_c <= 10'sd0) begin
      pack_c = {sign_q, 31'h0};
    end else begin
      pack_c = {sign_q, exp_r_c[7:0], mant_r_c};
    end
    final_c = special_q ? special_res_q : pack_c;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= StIdle;
      a_q           <= '0;
      b_q           <= '0;
      sign_q        <= 1'b0;
      special_q     <= 1'b0;
      special_res_q <= '0;
      ma_q          <= '0;
      mb_q          <= '0;
      ea_q          <= '0;
      eb_q          <= '0;
      prod_q        <= '0;
      exp_q         <= '0;
      mant_q        <= '0;
      g_q           <= 1'b0;
      s_q           <= 1'b0;
      bus.result    <= '0;
      bus.valid     <= 1'b0;
      bus.busy      <= 1'b0;
      bus.debug     <= '0;
    end else begin
      unique case (state)
        StIdle: begin
          bus.valid <= 1'b0;
          if (bus.enable) begin
            a_q      <= bus.a;
            b_q      <= bus.b;
            bus.busy <= 1'b1;
            state    <= StUnpack;
          end
        end
        StUnpack: begin
          sign_q        <= sign_c;
          special_q     <= special_c;
          special_res_q <= special_res_c;
          ma_q          <= ma;
          mb_q          <= mb;
          ea_q          <= ea;
          eb_q          <= eb;
          state         <= StMult;
        end
        StMult: begin
          prod_q    <= prod_c;
          exp_q     <= exp_sum_c;
          bus.debug <= prod_c[47:16];
          state     <= StNorm;
        end
        StNorm: begin
          // Product of two [1,2) mantissas lies in [1,4); bit 47 marks the [2,4) half.
          if (prod_q[47]) begin
            mant_q <= prod_q[46:24];
            g_q    <= prod_q[23];
            s_q    <= |prod_q[22:0];
            exp_q  <= exp_q + 10'sd1;
          end else begin
            mant_q <= prod_q[45:23];
            g_q    <= prod_q[22];
            s_q    <= |prod_q[21:0];
          end
          state <= StPack;
        end
        StPack: begin
          bus.result <= final_c;
          bus.valid  <= 1'b1;
          bus.busy   <= 1'b0;
          state      <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule
